mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter
//  Arbitrates instruction-fetch and data ports onto one shared memory port,
//  one outstanding transaction at a time, with bounded fetch starvation.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_imem_req,
   input  logic [31:0] i_imem_addr,
   output logic        o_imem_gnt,
   output logic        o_imem_rvld,
   output logic [31:0] o_imem_rdata,
   input  logic        i_dmem_req,
   input  logic        i_dmem_wen,
   input  logic [31:0] i_dmem_addr,
   input  logic [31:0] i_dmem_wdata,
   input  logic [3:0]  i_dmem_mask,
   output logic        o_dmem_gnt,
   output logic        o_dmem_rvld,
   output logic [31:0] o_dmem_rdata,
   output logic        o_mem_req,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_mask,
   input  logic        i_mem_ready,
   input  logic        i_mem_rvld,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       owner_is_data;
   logic [2:0] starve_cnt;
   logic       fetch_win;
   logic       accept;

   // Fetch only beats a pending data request once it has been passed over LIMIT times.
   assign fetch_win = i_imem_req && (!i_dmem_req || (starve_cnt == LIMIT));

   assign o_imem_rdata = i_mem_rdata;
   assign o_dmem_rdata = i_mem_rdata;

   always_comb begin
      o_mem_wen   = fetch_win ? 1'b0        : i_dmem_wen;
      o_mem_addr  = fetch_win ? i_imem_addr : i_dmem_addr;
      o_mem_wdata = fetch_win ? 32'd0       : i_dmem_wdata;
      o_mem_mask  = fetch_win ? 4'hF        : i_dmem_mask;
   end

   always_comb begin
      state_nxt   = state;
      o_mem_req   = 1'b0;
      o_imem_gnt  = 1'b0;
      o_dmem_gnt  = 1'b0;
      o_imem_rvld = 1'b0;
      o_dmem_rvld = 1'b0;
      o_busy      = 1'b0;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            o_mem_req = i_imem_req || i_dmem_req;
            if (o_mem_req && i_mem_ready) begin
               accept     = 1'b1;
               o_imem_gnt = fetch_win;
               o_dmem_gnt = !fetch_win;
               state_nxt  = WAIT;
            end
         end
         WAIT: begin
            o_busy = 1'b1;
            if (i_mem_rvld) begin
               o_imem_rvld = !owner_is_data;
               o_dmem_rvld = owner_is_data;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (i_rst) begin
         state_nxt   = IDLE;
         o_mem_req   = 1'b0;
         o_imem_gnt  = 1'b0;
         o_dmem_gnt  = 1'b0;
         o_imem_rvld = 1'b0;
         o_dmem_rvld = 1'b0;
         o_busy      = 1'b0;
         accept      = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         owner_is_data <= 1'b0;
         starve_cnt    <= 3'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner_is_data <= !fetch_win;
            if (fetch_win || !i_imem_req) begin
               starve_cnt <= 3'd0;
            end else if (starve_cnt < LIMIT) begin
               starve_cnt <= starve_cnt + 3'd1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter
//  Directed stimulus with a transaction-level reference model and literal checks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvld;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_wen;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_mask;
   logic        dmem_gnt, dmem_rvld;
   logic [31:0] dmem_rdata;
   logic        mem_req, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_mask;
   logic        mem_ready;
   logic        resp_rvld;
   logic        stray_rvld;
   wire logic   mem_rvld = resp_rvld | stray_rvld;
   logic [31:0] mem_rdata;
   logic        busy;

   int          n_cmp = 0;
   int          n_fail = 0;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_imem_req(imem_req), .i_imem_addr(imem_addr),
      .o_imem_gnt(imem_gnt), .o_imem_rvld(imem_rvld), .o_imem_rdata(imem_rdata),
      .i_dmem_req(dmem_req), .i_dmem_wen(dmem_wen), .i_dmem_addr(dmem_addr),
      .i_dmem_wdata(dmem_wdata), .i_dmem_mask(dmem_mask),
      .o_dmem_gnt(dmem_gnt), .o_dmem_rvld(dmem_rvld), .o_dmem_rdata(dmem_rdata),
      .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
      .i_mem_ready(mem_ready), .i_mem_rvld(mem_rvld), .i_mem_rdata(mem_rdata),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: raises rvld resp_delay cycles after an accept (0 = never).
   int          resp_delay = 0;
   int          cd = 0;
   logic [31:0] next_rdata = 32'd0;

   always @(negedge clk) begin
      if (!rst && (imem_gnt || dmem_gnt) && resp_delay > 0) cd = resp_delay;
   end

   always @(posedge clk) begin
      #1;
      resp_rvld = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            resp_rvld = 1'b1;
            mem_rdata = next_rdata;
         end
      end
   end

   // Reference model: a queue of outstanding owners (1 = data) plus a pass-over count.
   int          outstanding[$];
   int          starve = 0;
   logic        log_en = 1'b0;
   logic [63:0] gnt_log = 64'd0;

   always @(negedge clk) begin
      logic e_req, e_ig, e_dg, e_ir, e_dr, e_busy, fw;
      e_req = 0; e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_busy = 0; fw = 0;
      if (rst) begin
         outstanding.delete();
         starve = 0;
      end else if (outstanding.size() == 0) begin
         e_req = imem_req | dmem_req;
         fw    = imem_req && (!dmem_req || starve == LIMIT);
         if (e_req && mem_ready) begin
            if (fw) begin
               e_ig = 1; outstanding.push_back(0); starve = 0;
            end else begin
               e_dg = 1; outstanding.push_back(1);
               if (!imem_req) starve = 0;
               else if (starve < LIMIT) starve = starve + 1;
            end
         end
      end else begin
         e_busy = 1;
         if (mem_rvld) begin
            if (outstanding[0] == 1) e_dr = 1; else e_ir = 1;
            outstanding.delete(0);
         end
      end
      chk("m_mem_req", 64'(mem_req), 64'(e_req));
      chk("m_imem_gnt", 64'(imem_gnt), 64'(e_ig));
      chk("m_dmem_gnt", 64'(dmem_gnt), 64'(e_dg));
      chk("m_imem_rvld", 64'(imem_rvld), 64'(e_ir));
      chk("m_dmem_rvld", 64'(dmem_rvld), 64'(e_dr));
      chk("m_busy", 64'(busy), 64'(e_busy));
      if (e_req) begin
         chk("m_wen", 64'(mem_wen), fw ? 64'd0 : 64'(dmem_wen));
         chk("m_addr", 64'(mem_addr), fw ? 64'(imem_addr) : 64'(dmem_addr));
         chk("m_wdata", 64'(mem_wdata), fw ? 64'd0 : 64'(dmem_wdata));
         chk("m_mask", 64'(mem_mask), fw ? 64'hF : 64'(dmem_mask));
      end
      if (e_ir) chk("m_imem_rdata", 64'(imem_rdata), 64'(mem_rdata));
      if (e_dr) chk("m_dmem_rdata", 64'(dmem_rdata), 64'(mem_rdata));
      if (log_en && dmem_gnt) gnt_log = {gnt_log[55:0], 8'h44};
      if (log_en && imem_gnt) gnt_log = {gnt_log[55:0], 8'h49};
   end

   int dg_cnt, dr_cnt, ir_cnt;

   initial begin
      rst = 1; imem_req = 1; imem_addr = 32'h0; dmem_req = 0; dmem_wen = 0;
      dmem_addr = 0; dmem_wdata = 0; dmem_mask = 0; mem_ready = 1;
      resp_rvld = 0; stray_rvld = 0; mem_rdata = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_mem_req", 64'(mem_req), 64'd0);
         chk("rst_imem_gnt", 64'(imem_gnt), 64'd0);
         step();
      end

      // Fetch only, 2-cycle memory, accepted in the first cycle out of reset
      rst = 0; imem_addr = 32'h100; resp_delay = 2; next_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("f_gnt", 64'(imem_gnt), 64'd1);
      chk("f_mask", 64'(mem_mask), 64'hF);
      chk("f_addr", 64'(mem_addr), 64'h100);
      chk("f_wen", 64'(mem_wen), 64'd0);
      step(); imem_req = 0;
      @(negedge clk);
      chk("f_busy1", 64'(busy), 64'd1);
      chk("f_rvld1", 64'(imem_rvld), 64'd0);
      step();
      @(negedge clk);
      chk("f_rvld2", 64'(imem_rvld), 64'd1);
      chk("f_rdata", 64'(imem_rdata), 64'hDEADBEEF);
      chk("f_busy2", 64'(busy), 64'd1);
      step();
      @(negedge clk);
      chk("f_busy3", 64'(busy), 64'd0);

      // Simultaneous fetch and store: store first
      step();
      imem_req = 1; imem_addr = 32'h300;
      dmem_req = 1; dmem_wen = 1; dmem_addr = 32'h200; dmem_wdata = 32'h12345678;
      dmem_mask = 4'b0011; resp_delay = 1; next_rdata = 32'h0;
      @(negedge clk);
      chk("s_dgnt", 64'(dmem_gnt), 64'd1);
      chk("s_ignt", 64'(imem_gnt), 64'd0);
      chk("s_wen", 64'(mem_wen), 64'd1);
      chk("s_addr", 64'(mem_addr), 64'h200);
      chk("s_wdata", 64'(mem_wdata), 64'h12345678);
      chk("s_mask", 64'(mem_mask), 64'h3);
      step(); dmem_req = 0;
      @(negedge clk);
      chk("s_ack", 64'(dmem_rvld), 64'd1);
      chk("s_no_irvld", 64'(imem_rvld), 64'd0);
      step(); next_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("s_fetch_gnt", 64'(imem_gnt), 64'd1);
      chk("s_fetch_addr", 64'(mem_addr), 64'h300);
      step(); imem_req = 0;
      @(negedge clk);
      chk("s_fetch_rdata", 64'(imem_rdata), 64'hCAFEF00D);
      step();

      // Starvation pattern with continuous requests
      gnt_log = 64'd0; log_en = 1;
      imem_req = 1; imem_addr = 32'h400;
      dmem_req = 1; dmem_wen = 0; dmem_addr = 32'h500; dmem_mask = 4'hF; next_rdata = 32'h55AA;
      repeat (16) step();
      log_en = 0; imem_req = 0; dmem_req = 0;
      step(); step();
      chk("starve_seq", gnt_log, 64'h4444444944444449);

      // Ready stall with counter at limit: fetch must be the standing winner
      imem_req = 1; dmem_req = 1;
      repeat (6) step();
      mem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_ignt", 64'(imem_gnt), 64'd0);
         chk("stall_dgnt", 64'(dmem_gnt), 64'd0);
         chk("stall_addr", 64'(mem_addr), 64'h400);
         step();
      end
      mem_ready = 1;
      @(negedge clk);
      chk("stall_release", 64'(imem_gnt), 64'd1);
      step(); imem_req = 0; dmem_req = 0;
      step(); step();

      // Reset during WAIT, then a stray response
      resp_delay = 0; dmem_req = 1; dmem_wen = 0; dmem_addr = 32'h600;
      @(negedge clk);
      chk("r_gnt", 64'(dmem_gnt), 64'd1);
      step(); dmem_req = 0;
      @(negedge clk);
      chk("r_busy", 64'(busy), 64'd1);
      step(); rst = 1;
      @(negedge clk);
      chk("r_rst_busy", 64'(busy), 64'd0);
      step();
      step(); rst = 0;
      step(); stray_rvld = 1;
      @(negedge clk);
      chk("r_stray_d", 64'(dmem_rvld), 64'd0);
      chk("r_stray_i", 64'(imem_rvld), 64'd0);
      chk("r_stray_busy", 64'(busy), 64'd0);
      step(); stray_rvld = 0;
      @(negedge clk);
      chk("r_idle_busy", 64'(busy), 64'd0);
      step();

      // Store then back-to-back loads
      resp_delay = 1; dmem_req = 1; dmem_wen = 1; dmem_addr = 32'h700;
      dmem_wdata = 32'hA5A5A5A5; dmem_mask = 4'hC; next_rdata = 32'h1111;
      dg_cnt = 0; dr_cnt = 0; ir_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         dg_cnt += int'(dmem_gnt);
         dr_cnt += int'(dmem_rvld);
         ir_cnt += int'(imem_rvld);
         step();
         if (i == 0) dmem_wen = 0;
      end
      dmem_req = 0;
      step(); step();
      chk("ld_gnts", 64'(dg_cnt), 64'd4);
      chk("ld_rvlds", 64'(dr_cnt), 64'd4);
      chk("ld_no_irvld", 64'(ir_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
